// File: rtl/eth_phy_rx_lane_lock_pkg.sv
// Shared definitions for the multi-lane 64b/66b RX block-lock monitor.
//   SYNC_DATA / SYNC_CTRL : the only two legal 66b sync headers
//   lane_state_t          : per-lane block-lock FSM encoding
package eth_phy_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_SLIP   = 2'd2,
    ST_HOLD   = 2'd3
  } lane_state_t;

endpackage

// File: rtl/eth_phy_rx_lane_lock_if.sv
// SERDES gearbox <-> lane-lock monitor bundle.
//   serdes_rx_hdr       : sync headers, lane i at [i*HDR_WIDTH +: HDR_WIDTH]
//   serdes_rx_hdr_valid : per-lane header qualifier
//   serdes_rx_bitslip   : per-lane bitslip request back to the SERDES
//   serdes_rx_reset_req : per-lane one-cycle SERDES reset request
// master = gearbox/SERDES side, slave = lane-lock monitor.
interface eth_phy_rx_lane_lock_if #(
  parameter int LANES     = 4,
  parameter int HDR_WIDTH = 2
);
  logic [LANES*HDR_WIDTH-1:0] serdes_rx_hdr;
  logic [LANES-1:0]           serdes_rx_hdr_valid;
  logic [LANES-1:0]           serdes_rx_bitslip;
  logic [LANES-1:0]           serdes_rx_reset_req;

  modport master (
    output serdes_rx_hdr, serdes_rx_hdr_valid,
    input  serdes_rx_bitslip, serdes_rx_reset_req
  );

  modport slave (
    input  serdes_rx_hdr, serdes_rx_hdr_valid,
    output serdes_rx_bitslip, serdes_rx_reset_req
  );
endinterface

// File: rtl/eth_phy_rx_lane_lock_lane.sv
// One 66b lane: block-lock FSM with bitslip sequencing, slip budget with
// SERDES reset request, and high-BER detection against a shared window.
//   clk, rst   : clock, async active-high reset
//   enable     : lane participates; when low the lane is held idle
//   hdr_valid  : qualifier for hdr
//   hdr        : sync header
//   win_wrap   : last cycle of the shared BER window
//   bitslip    : bitslip request (combinational from state)
//   reset_req  : one-cycle SERDES reset request
//   block_lock : registered block lock
//   high_ber   : registered high-BER flag
module eth_phy_rx_lane_lock_lane
  import eth_phy_pkg::*;
#(
  parameter int HDR_WIDTH           = 2,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int BER_THRESHOLD       = 16,
  parameter int LOCK_VALID_COUNT    = 64,
  parameter int LOCK_INVALID_MAX    = 16,
  parameter int MAX_SLIPS           = 132
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 hdr_valid,
  input  logic [HDR_WIDTH-1:0] hdr,
  input  logic                 win_wrap,
  output logic                 bitslip,
  output logic                 reset_req,
  output logic                 block_lock,
  output logic                 high_ber
);

  localparam int SH_W    = $clog2(LOCK_VALID_COUNT + 1);
  localparam int INV_W   = $clog2(LOCK_INVALID_MAX + 1);
  localparam int SLIP_W  = $clog2(MAX_SLIPS + 1);
  localparam int BER_W   = $clog2(BER_THRESHOLD + 1);
  localparam int TMR_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                           BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  lane_state_t       state, state_next;
  logic [SH_W-1:0]   sh_cnt;
  logic [INV_W-1:0]  inv_cnt;
  logic [SLIP_W-1:0] slip_cnt;
  logic [TMR_W-1:0]  tmr;
  logic [BER_W-1:0]  ber_cnt;

  logic hdr_ok, eval, bad, win_done, inv_limit, slip_start, lock_gain;

  // Headers only count while hunting or locked; SLIP/HOLD ignore them.
  always_comb begin
    hdr_ok     = (hdr == HDR_WIDTH'(SYNC_DATA)) || (hdr == HDR_WIDTH'(SYNC_CTRL));
    eval       = hdr_valid && ((state == ST_HUNT) || (state == ST_LOCKED));
    bad        = eval && !hdr_ok;
    win_done   = eval && (sh_cnt == SH_W'(LOCK_VALID_COUNT - 1));
    inv_limit  = bad && (inv_cnt == INV_W'(LOCK_INVALID_MAX - 1));
    // Reaching the invalid limit wins over completing the window.
    slip_start = ((state == ST_HUNT) && bad) || ((state == ST_LOCKED) && inv_limit);
    lock_gain  = (state == ST_HUNT) && win_done && !bad && (inv_cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_HUNT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = ST_HUNT;
    end else begin
      case (state)
        ST_HUNT:   if (bad) state_next = ST_SLIP;
                   else if (lock_gain) state_next = ST_LOCKED;
        ST_LOCKED: if (inv_limit) state_next = ST_SLIP;
        ST_SLIP:   if (tmr == TMR_W'(BITSLIP_HIGH_CYCLES - 1)) state_next = ST_HOLD;
        ST_HOLD:   if (tmr == TMR_W'(BITSLIP_LOW_CYCLES - 1)) state_next = ST_HUNT;
        default:   state_next = ST_HUNT;
      endcase
    end
  end

  // Bitslip follows the state directly so reset drops it asynchronously.
  always_comb begin
    bitslip = (state == ST_SLIP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_cnt     <= '0;
      inv_cnt    <= '0;
      slip_cnt   <= '0;
      tmr        <= '0;
      ber_cnt    <= '0;
      block_lock <= 1'b0;
      high_ber   <= 1'b0;
      reset_req  <= 1'b0;
    end else if (!enable) begin
      sh_cnt     <= '0;
      inv_cnt    <= '0;
      slip_cnt   <= '0;
      tmr        <= '0;
      ber_cnt    <= '0;
      block_lock <= 1'b0;
      high_ber   <= 1'b0;
      reset_req  <= 1'b0;
    end else begin
      if (slip_start || win_done) begin
        sh_cnt  <= '0;
        inv_cnt <= '0;
      end else if (eval) begin
        sh_cnt  <= sh_cnt + SH_W'(1);
        inv_cnt <= inv_cnt + INV_W'(bad);
      end

      // Timer measures time spent in SLIP and then HOLD.
      if (((state == ST_SLIP) || (state == ST_HOLD)) && (state_next == state))
        tmr <= tmr + TMR_W'(1);
      else
        tmr <= '0;

      if (lock_gain)       block_lock <= 1'b1;
      else if (slip_start) block_lock <= 1'b0;

      // Budget exhausted: request a SERDES reset but still perform the slip.
      reset_req <= 1'b0;
      if (lock_gain) begin
        slip_cnt <= '0;
      end else if (slip_start) begin
        if (slip_cnt == SLIP_W'(MAX_SLIPS - 1)) begin
          slip_cnt  <= '0;
          reset_req <= 1'b1;
        end else begin
          slip_cnt <= slip_cnt + SLIP_W'(1);
        end
      end

      // An invalid header on the wrap cycle belongs to the new window.
      if ((state != ST_LOCKED) || slip_start) begin
        ber_cnt  <= '0;
        high_ber <= 1'b0;
      end else if (win_wrap) begin
        high_ber <= (ber_cnt >= BER_W'(BER_THRESHOLD));
        ber_cnt  <= bad ? BER_W'(1) : '0;
      end else begin
        if (bad && (ber_cnt != BER_W'(BER_THRESHOLD))) ber_cnt <= ber_cnt + BER_W'(1);
        if (ber_cnt >= BER_W'(BER_THRESHOLD)) high_ber <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_phy_rx_lane_lock.sv
// Multi-lane 64b/66b RX sync-header monitor top.
//   clk, rst          : clock, async active-high reset
//   serdes            : gearbox bundle (headers in, bitslip/reset requests out)
//   cfg_lane_enable   : per-lane participation
//   rx_block_lock     : per-lane block lock
//   rx_high_ber       : per-lane high BER
//   rx_block_lock_all : all enabled lanes locked (registered)
//   rx_high_ber_any   : any enabled lane high BER (registered)
//   rx_status         : overall link good (registered)
module eth_phy_rx_lane_lock
  import eth_phy_pkg::*;
#(
  parameter int LANES               = 4,
  parameter int HDR_WIDTH           = 2,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int COUNT_125US         = 19531,
  parameter int BER_THRESHOLD       = 16,
  parameter int LOCK_VALID_COUNT    = 64,
  parameter int LOCK_INVALID_MAX    = 16,
  parameter int MAX_SLIPS           = 132
) (
  input  logic                        clk,
  input  logic                        rst,
  eth_phy_rx_lane_lock_if.slave       serdes,
  input  logic [LANES-1:0]            cfg_lane_enable,
  output logic [LANES-1:0]            rx_block_lock,
  output logic [LANES-1:0]            rx_high_ber,
  output logic                        rx_block_lock_all,
  output logic                        rx_high_ber_any,
  output logic                        rx_status
);

  localparam int WIN_W = $clog2(COUNT_125US + 1);

  logic [WIN_W-1:0] win_cnt;
  logic             win_wrap;
  logic [LANES-1:0] bitslip_w, reset_req_w;
  logic             lock_all_d, ber_any_d;

  assign win_wrap = (win_cnt == WIN_W'(COUNT_125US - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           win_cnt <= '0;
    else if (win_wrap) win_cnt <= '0;
    else               win_cnt <= win_cnt + WIN_W'(1);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    eth_phy_rx_lane_lock_lane #(
      .HDR_WIDTH           (HDR_WIDTH),
      .BITSLIP_HIGH_CYCLES (BITSLIP_HIGH_CYCLES),
      .BITSLIP_LOW_CYCLES  (BITSLIP_LOW_CYCLES),
      .BER_THRESHOLD       (BER_THRESHOLD),
      .LOCK_VALID_COUNT    (LOCK_VALID_COUNT),
      .LOCK_INVALID_MAX    (LOCK_INVALID_MAX),
      .MAX_SLIPS           (MAX_SLIPS)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .enable     (cfg_lane_enable[i]),
      .hdr_valid  (serdes.serdes_rx_hdr_valid[i]),
      .hdr        (serdes.serdes_rx_hdr[i*HDR_WIDTH +: HDR_WIDTH]),
      .win_wrap   (win_wrap),
      .bitslip    (bitslip_w[i]),
      .reset_req  (reset_req_w[i]),
      .block_lock (rx_block_lock[i]),
      .high_ber   (rx_high_ber[i])
    );
  end

  assign serdes.serdes_rx_bitslip   = bitslip_w;
  assign serdes.serdes_rx_reset_req = reset_req_w;

  // Disabled lanes count as locked and never as high BER.
  always_comb begin
    lock_all_d = &(rx_block_lock | ~cfg_lane_enable);
    ber_any_d  = |(rx_high_ber & cfg_lane_enable);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_block_lock_all <= 1'b0;
      rx_high_ber_any   <= 1'b0;
      rx_status         <= 1'b0;
    end else begin
      rx_block_lock_all <= lock_all_d;
      rx_high_ber_any   <= ber_any_d;
      rx_status         <= lock_all_d & ~ber_any_d & (cfg_lane_enable != '0);
    end
  end

endmodule
